// File: rtl/edge_det_pkg.sv
// Shared state encoding and default widths for the edge/threshold detector.
package edge_det_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_QUAL_W = 8;
  localparam int DEF_TO_W   = 16;

  typedef enum logic [2:0] {
    ST_LOW,
    ST_RISE_Q,
    ST_HIGH,
    ST_FALL_Q,
    ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/edge_threshold_detect_sample_qualifier.sv
// Saturating consecutive-match counter shared by rise and fall qualification.
// reached reports whether the count after this cycle's command meets the hold.
module sample_qualifier
  import edge_det_pkg::*;
#(
  parameter int QUAL_W = DEF_QUAL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  input  logic [QUAL_W-1:0] hold_cnt,
  output logic              reached
);

  localparam logic [QUAL_W-1:0] Q_ONE = {{(QUAL_W-1){1'b0}}, 1'b1};
  localparam logic [QUAL_W-1:0] Q_MAX = {QUAL_W{1'b1}};

  logic [QUAL_W-1:0] qcnt;
  logic [QUAL_W-1:0] qcnt_nxt;
  logic [QUAL_W-1:0] eff_hold;

  always_comb begin
    eff_hold = (hold_cnt == '0) ? Q_ONE : hold_cnt;
    qcnt_nxt = qcnt;
    if (clr) begin
      qcnt_nxt = '0;
    end else if (load) begin
      qcnt_nxt = Q_ONE;
    end else if (inc && (qcnt != Q_MAX)) begin
      qcnt_nxt = qcnt + Q_ONE;
    end
    reached = !clr && (load || inc) && (qcnt_nxt >= eff_hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt <= '0;
    end else begin
      qcnt <= qcnt_nxt;
    end
  end

endmodule

// File: rtl/edge_threshold_detect.sv
// Hysteresis edge detector with hold-count qualification and registered strobes.
// Optional pulse timeout with lockout is enabled by defining EDGE_DET_TIMEOUT_EN.
module edge_threshold_detect
  import edge_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int QUAL_W = DEF_QUAL_W,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  input  logic signed [DATA_W-1:0] hi_thresh,
  input  logic signed [DATA_W-1:0] lo_thresh,
  input  logic        [QUAL_W-1:0] hold_cnt,
  input  logic        [TO_W-1:0]   max_len,
  output logic                     rising_edge,
  output logic                     falling_edge,
  output logic                     level,
  output logic                     abort,
  output logic                     cfg_err
);

  state_t state, state_nxt;
  logic   above, below;
  logic   q_clr, q_load, q_inc, q_reached;
  logic   rise_nxt, fall_nxt;

`ifdef EDGE_DET_TIMEOUT_EN
  localparam logic [TO_W-1:0] T_ONE = {{(TO_W-1){1'b0}}, 1'b1};
  logic [TO_W-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic            timeout, abort_nxt, abort_q;
`else
  logic unused_max_len;
  assign unused_max_len = ^max_len;
  assign abort          = 1'b0;
`endif

  assign above = (sample_data >= hi_thresh);
  assign below = (sample_data <= lo_thresh);
  assign level = (state == ST_HIGH) || (state == ST_FALL_Q);

  sample_qualifier #(.QUAL_W(QUAL_W)) u_qual (
    .clk      (clk),
    .rst      (rst),
    .clr      (q_clr),
    .load     (q_load),
    .inc      (q_inc),
    .hold_cnt (hold_cnt),
    .reached  (q_reached)
  );

  always_comb begin
    state_nxt = state;
    q_clr     = 1'b0;
    q_load    = 1'b0;
    q_inc     = 1'b0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
`ifdef EDGE_DET_TIMEOUT_EN
    abort_nxt = 1'b0;
    tcnt_nxt  = tcnt;
    tcnt_inc  = (tcnt == {TO_W{1'b1}}) ? tcnt : tcnt + T_ONE;
    timeout   = (max_len != '0) && (tcnt_inc >= max_len);
`endif
    // A bad threshold pair overrides everything; only a live pulse gets closed.
    if (cfg_err) begin
      state_nxt = ST_LOW;
      q_clr     = 1'b1;
      fall_nxt  = (state == ST_HIGH) || (state == ST_FALL_Q);
`ifdef EDGE_DET_TIMEOUT_EN
      tcnt_nxt  = '0;
`endif
    end else if (sample_valid) begin
      case (state)
        ST_LOW: begin
          if (above) begin
            q_load = 1'b1;
            if (q_reached) begin
              state_nxt = ST_HIGH;
              rise_nxt  = 1'b1;
`ifdef EDGE_DET_TIMEOUT_EN
              tcnt_nxt  = '0;
`endif
            end else begin
              state_nxt = ST_RISE_Q;
            end
          end else begin
            q_clr = 1'b1;
          end
        end
        ST_RISE_Q: begin
          if (above) begin
            q_inc = 1'b1;
            if (q_reached) begin
              state_nxt = ST_HIGH;
              rise_nxt  = 1'b1;
`ifdef EDGE_DET_TIMEOUT_EN
              tcnt_nxt  = '0;
`endif
            end
          end else begin
            q_clr     = 1'b1;
            state_nxt = ST_LOW;
          end
        end
        ST_HIGH: begin
`ifdef EDGE_DET_TIMEOUT_EN
          tcnt_nxt = tcnt_inc;
          if (timeout) begin
            state_nxt = ST_LOCKOUT;
            abort_nxt = 1'b1;
            q_clr     = 1'b1;
          end else
`endif
          if (below) begin
            q_load = 1'b1;
            if (q_reached) begin
              state_nxt = ST_LOW;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = ST_FALL_Q;
            end
          end else begin
            q_clr = 1'b1;
          end
        end
        ST_FALL_Q: begin
`ifdef EDGE_DET_TIMEOUT_EN
          tcnt_nxt = tcnt_inc;
          if (timeout) begin
            state_nxt = ST_LOCKOUT;
            abort_nxt = 1'b1;
            q_clr     = 1'b1;
          end else
`endif
          if (below) begin
            q_inc = 1'b1;
            if (q_reached) begin
              state_nxt = ST_LOW;
              fall_nxt  = 1'b1;
            end
          end else begin
            q_clr     = 1'b1;
            state_nxt = ST_HIGH;
          end
        end
`ifdef EDGE_DET_TIMEOUT_EN
        ST_LOCKOUT: begin
          if (below) begin
            state_nxt = ST_LOW;
          end
        end
`endif
        default: begin
          state_nxt = ST_LOW;
          q_clr     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_LOW;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      rising_edge  <= rise_nxt;
      falling_edge <= fall_nxt;
      cfg_err      <= (lo_thresh > hi_thresh);
    end
  end

`ifdef EDGE_DET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt    <= '0;
      abort_q <= 1'b0;
    end else begin
      tcnt    <= tcnt_nxt;
      abort_q <= abort_nxt;
    end
  end

  assign abort = abort_q;
`endif

endmodule
